// File: rtl/nonogram_pkg.sv
// Shared definitions for the nonogram flow controller.
//   state_e          : top-level flow state, and its encoding is the phase output code
//   ERR_*            : err_code values reported while in FAULT
//   DEF_MAX_ROWS/COLS: default board dimension limits
package nonogram_pkg;

    typedef enum logic [1:0] {
        ST_RECEIVE  = 2'd0,
        ST_SOLVE    = 2'd1,
        ST_TRANSMIT = 2'd2,
        ST_FAULT    = 2'd3
    } state_e;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_OVF     = 3'd1;
    localparam logic [2:0] ERR_UNSOLV  = 3'd2;
    localparam logic [2:0] ERR_TIMEOUT = 3'd3;
    localparam logic [2:0] ERR_BAD_DIM = 3'd4;

    localparam int unsigned DEF_MAX_ROWS = 11;
    localparam int unsigned DEF_MAX_COLS = 11;

endpackage

// File: rtl/nonogram_flow_ctrl_if.sv
// Line-FIFO write port shared between the flow controller and the FIFO.
//   fifo_wr_en : write strobe (controller -> FIFO)
//   fifo_din   : write data, LINE_W bits (controller -> FIFO)
//   fifo_flush : synchronous clear pulse (controller -> FIFO)
//   fifo_full  : FIFO cannot accept a write (FIFO -> controller)
interface nonogram_flow_ctrl_if #(
    parameter int unsigned LINE_W = 16
);
    logic              fifo_wr_en;
    logic [LINE_W-1:0] fifo_din;
    logic              fifo_flush;
    logic              fifo_full;

    modport master (
        output fifo_wr_en,
        output fifo_din,
        output fifo_flush,
        input  fifo_full
    );

    modport slave (
        input  fifo_wr_en,
        input  fifo_din,
        input  fifo_flush,
        output fifo_full
    );
endinterface

// File: rtl/nonogram_watchdog.sv
// Clear/enable counter that flags expiry on the LIMIT-th enabled cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_clear    : force count to zero (wins over i_enable)
//   i_enable   : count this cycle
//   o_expire   : high in the enabled cycle whose count is LIMIT-1
module nonogram_watchdog #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);
    localparam int unsigned CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] TERM = CW'(LIMIT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && (r_cnt != TERM)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_expire = i_enable && (r_cnt == TERM);
endmodule

// File: rtl/nonogram_flow_ctrl.sv
// Sequences one nonogram board through receive -> solve -> transmit, muxes
// the parser/solver line writes onto the shared FIFO and traps faults.
//   clk, rst_n              : clock, asynchronous active-low reset
//   parse_* / solve_*       : line-write sources and board-parsed pulse
//   solved/unsolvable       : solver result pulses
//   assembled               : transmit of current board complete
//   clear_err               : leave FAULT
//   rx_valid/rx_byte, tx_done/tx_byte : byte tap captured into disp
//   fifo                    : line-FIFO write port (master side)
//   solve_start/asm_start   : first-cycle pulses of SOLVE / TRANSMIT
//   rows_q/cols_q           : dimensions of the accepted board
//   phase, err_code, boards_done, disp : status
module nonogram_flow_ctrl
    import nonogram_pkg::*;
#(
    parameter int unsigned MAX_ROWS       = DEF_MAX_ROWS,
    parameter int unsigned MAX_COLS       = DEF_MAX_COLS,
    parameter int unsigned LINE_W         = 16,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            parse_done,
    input  logic                            parse_write,
    input  logic [LINE_W-1:0]               parse_line,
    input  logic [$clog2(MAX_ROWS+1)-1:0]   parse_rows,
    input  logic [$clog2(MAX_COLS+1)-1:0]   parse_cols,
    input  logic                            solve_write,
    input  logic [LINE_W-1:0]               solve_line,
    input  logic                            solved,
    input  logic                            unsolvable,
    input  logic                            assembled,
    input  logic                            clear_err,
    input  logic                            rx_valid,
    input  logic [7:0]                      rx_byte,
    input  logic                            tx_done,
    input  logic [7:0]                      tx_byte,
    nonogram_flow_ctrl_if.master            fifo,
    output logic                            solve_start,
    output logic                            asm_start,
    output logic [$clog2(MAX_ROWS+1)-1:0]   rows_q,
    output logic [$clog2(MAX_COLS+1)-1:0]   cols_q,
    output logic [1:0]                      phase,
    output logic [2:0]                      err_code,
    output logic [7:0]                      boards_done,
    output logic [7:0]                      disp
);
    localparam int unsigned RW = $clog2(MAX_ROWS + 1);
    localparam int unsigned CW = $clog2(MAX_COLS + 1);
    localparam logic [RW-1:0] ROWS_MAX = RW'(MAX_ROWS);
    localparam logic [CW-1:0] COLS_MAX = CW'(MAX_COLS);

    state_e            r_state, w_next;
    logic [2:0]        r_err, w_err_next;
    logic [RW-1:0]     r_rows;
    logic [CW-1:0]     r_cols;
    logic [7:0]        r_boards, r_disp;
    logic              r_solve_start, r_asm_start, r_flush;
    logic              w_wr_req, w_ovf, w_dims_ok, w_load_dim, w_bump, w_expire;
    logic [LINE_W-1:0] w_wr_line;

    nonogram_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (r_state != ST_SOLVE),
        .i_enable (r_state == ST_SOLVE),
        .o_expire (w_expire)
    );

    assign w_dims_ok = (parse_rows != '0) && (parse_rows <= ROWS_MAX) &&
                       (parse_cols != '0) && (parse_cols <= COLS_MAX);

    always_comb begin
        w_wr_req  = 1'b0;
        w_wr_line = '0;
        case (r_state)
            ST_RECEIVE: begin
                w_wr_req  = parse_write;
                w_wr_line = parse_line;
            end
            ST_SOLVE: begin
                w_wr_req  = solve_write;
                w_wr_line = solve_line;
            end
            default: ;
        endcase
    end

    assign w_ovf           = w_wr_req & fifo.fifo_full;
    assign fifo.fifo_wr_en = w_wr_req & ~fifo.fifo_full;
    assign fifo.fifo_din   = w_wr_line;
    assign fifo.fifo_flush = r_flush;

    // Overflow is tested first in every state that can write, so it outranks
    // parse_done/solved arriving in the same cycle.
    always_comb begin
        w_next     = r_state;
        w_err_next = r_err;
        w_load_dim = 1'b0;
        w_bump     = 1'b0;
        case (r_state)
            ST_RECEIVE: begin
                if (w_ovf) begin
                    w_next     = ST_FAULT;
                    w_err_next = ERR_OVF;
                end else if (parse_done) begin
                    if (w_dims_ok) begin
                        w_next     = ST_SOLVE;
                        w_load_dim = 1'b1;
                    end else begin
                        w_next     = ST_FAULT;
                        w_err_next = ERR_BAD_DIM;
                    end
                end
            end
            ST_SOLVE: begin
                if (w_ovf) begin
                    w_next     = ST_FAULT;
                    w_err_next = ERR_OVF;
                end else if (solved) begin
                    w_next = ST_TRANSMIT;
                end else if (unsolvable) begin
                    w_next     = ST_FAULT;
                    w_err_next = ERR_UNSOLV;
                end else if (w_expire) begin
                    w_next     = ST_FAULT;
                    w_err_next = ERR_TIMEOUT;
                end
            end
            ST_TRANSMIT: begin
                if (assembled) begin
                    w_next = ST_RECEIVE;
                    w_bump = 1'b1;
                end
            end
            ST_FAULT: begin
                if (clear_err) begin
                    w_next     = ST_RECEIVE;
                    w_err_next = ERR_NONE;
                end
            end
            default: w_next = ST_RECEIVE;
        endcase
    end

    // Pulses are registered from the transition so they coincide with the
    // first cycle of the new state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_RECEIVE;
            r_err         <= ERR_NONE;
            r_rows        <= '0;
            r_cols        <= '0;
            r_boards      <= '0;
            r_disp        <= '0;
            r_solve_start <= 1'b0;
            r_asm_start   <= 1'b0;
            r_flush       <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_err         <= w_err_next;
            r_solve_start <= (w_next != r_state) && (w_next == ST_SOLVE);
            r_asm_start   <= (w_next != r_state) && (w_next == ST_TRANSMIT);
            r_flush       <= (w_next != r_state) &&
                             ((w_next == ST_TRANSMIT) || (w_next == ST_FAULT) ||
                              ((w_next == ST_RECEIVE) && (r_state == ST_FAULT)));
            if (w_load_dim) begin
                r_rows <= parse_rows;
                r_cols <= parse_cols;
            end
            if (w_bump && (r_boards != '1)) begin
                r_boards <= r_boards + 8'd1;
            end
            if (rx_valid) begin
                r_disp <= rx_byte;
            end else if (tx_done) begin
                r_disp <= tx_byte;
            end
        end
    end

    assign phase       = r_state;
    assign err_code    = r_err;
    assign rows_q      = r_rows;
    assign cols_q      = r_cols;
    assign boards_done = r_boards;
    assign disp        = r_disp;
    assign solve_start = r_solve_start;
    assign asm_start   = r_asm_start;
endmodule

// File: tb/tb_nonogram_flow_ctrl.sv
// Directed bench for nonogram_flow_ctrl: a vector table for single-cycle
// behaviour plus hand-written sequences for watchdog, saturation and reset.
module tb_nonogram_flow_ctrl;
    import nonogram_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        parse_done, parse_write, solve_write, solved, unsolvable;
    logic        assembled, clear_err, rx_valid, tx_done;
    logic [15:0] parse_line, solve_line;
    logic [3:0]  parse_rows, parse_cols;
    logic [7:0]  rx_byte, tx_byte;
    logic        solve_start, asm_start;
    logic [3:0]  rows_q, cols_q;
    logic [1:0]  phase;
    logic [2:0]  err_code;
    logic [7:0]  boards_done, disp;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    nonogram_flow_ctrl_if #(.LINE_W(16)) fif ();

    nonogram_flow_ctrl #(
        .MAX_ROWS       (11),
        .MAX_COLS       (11),
        .LINE_W         (16),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .parse_done  (parse_done),
        .parse_write (parse_write),
        .parse_line  (parse_line),
        .parse_rows  (parse_rows),
        .parse_cols  (parse_cols),
        .solve_write (solve_write),
        .solve_line  (solve_line),
        .solved      (solved),
        .unsolvable  (unsolvable),
        .assembled   (assembled),
        .clear_err   (clear_err),
        .rx_valid    (rx_valid),
        .rx_byte     (rx_byte),
        .tx_done     (tx_done),
        .tx_byte     (tx_byte),
        .fifo        (fif),
        .solve_start (solve_start),
        .asm_start   (asm_start),
        .rows_q      (rows_q),
        .cols_q      (cols_q),
        .phase       (phase),
        .err_code    (err_code),
        .boards_done (boards_done),
        .disp        (disp)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        pd, pw;
        logic [15:0] pl;
        logic [3:0]  pr, pc;
        logic        sw;
        logic [15:0] sl;
        logic        sv, us, asm, full, clr, rxv;
        logic [7:0]  rxb;
        logic        txd;
        logic [7:0]  txb;
        logic        e_wr;
        logic [15:0] e_din;
        logic [1:0]  e_ph;
        logic [2:0]  e_err;
        logic        e_ss, e_as, e_fl;
        logic [3:0]  e_rows, e_cols;
        logic [7:0]  e_bd, e_disp;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clr_in();
        parse_done = 0; parse_write = 0; parse_line = '0; parse_rows = '0; parse_cols = '0;
        solve_write = 0; solve_line = '0; solved = 0; unsolvable = 0; assembled = 0;
        clear_err = 0; rx_valid = 0; rx_byte = '0; tx_done = 0; tx_byte = '0;
        fif.fifo_full = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v);
        parse_done = v.pd; parse_write = v.pw; parse_line = v.pl;
        parse_rows = v.pr; parse_cols = v.pc;
        solve_write = v.sw; solve_line = v.sl; solved = v.sv; unsolvable = v.us;
        assembled = v.asm; fif.fifo_full = v.full; clear_err = v.clr;
        rx_valid = v.rxv; rx_byte = v.rxb; tx_done = v.txd; tx_byte = v.txb;
    endtask

    task automatic board(input logic [3:0] r, input logic [3:0] c);
        parse_done = 1; parse_rows = r; parse_cols = c;
        tick(); clr_in();
        solved = 1;
        tick(); clr_in();
        assembled = 1;
        tick(); clr_in();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL sim_time_limit: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int unsigned exp_bd;
        clr_in();

        // Vector table: inputs held for one cycle, wr/din checked during
        // the cycle, everything else checked after the edge.
        vecs.push_back('{pw:1, pl:16'h1234, e_wr:1, e_din:16'h1234, default:0});
        vecs.push_back('{pd:1, pr:11, pc:11, rxv:1, rxb:8'hA5, txd:1, txb:8'h3C,
                         e_ph:1, e_ss:1, e_rows:11, e_cols:11, e_disp:8'hA5, default:0});
        vecs.push_back('{sw:1, sl:16'hBEEF, e_wr:1, e_din:16'hBEEF,
                         e_ph:1, e_rows:11, e_cols:11, e_disp:8'hA5, default:0});
        vecs.push_back('{pw:1, pl:16'h7777, pd:1, pr:3, pc:3,
                         e_ph:1, e_rows:11, e_cols:11, e_disp:8'hA5, default:0});
        vecs.push_back('{sv:1, us:1, e_ph:2, e_as:1, e_fl:1,
                         e_rows:11, e_cols:11, e_disp:8'hA5, default:0});
        vecs.push_back('{sw:1, sl:16'h1111, e_ph:2, e_rows:11, e_cols:11, e_disp:8'hA5, default:0});
        vecs.push_back('{txd:1, txb:8'h3C, e_ph:2, e_rows:11, e_cols:11, e_disp:8'h3C, default:0});
        vecs.push_back('{asm:1, e_ph:0, e_rows:11, e_cols:11, e_bd:1, e_disp:8'h3C, default:0});
        vecs.push_back('{pd:1, pr:12, pc:5, e_ph:3, e_err:4, e_fl:1,
                         e_rows:11, e_cols:11, e_bd:1, e_disp:8'h3C, default:0});
        vecs.push_back('{pd:1, pr:3, pc:3, sv:1, asm:1, pw:1, e_ph:3, e_err:4,
                         e_rows:11, e_cols:11, e_bd:1, e_disp:8'h3C, default:0});
        vecs.push_back('{clr:1, e_ph:0, e_fl:1, e_rows:11, e_cols:11, e_bd:1, e_disp:8'h3C, default:0});
        vecs.push_back('{pd:1, pr:0, pc:5, e_ph:3, e_err:4, e_fl:1,
                         e_rows:11, e_cols:11, e_bd:1, e_disp:8'h3C, default:0});
        vecs.push_back('{clr:1, e_fl:1, e_rows:11, e_cols:11, e_bd:1, e_disp:8'h3C, default:0});
        vecs.push_back('{pd:1, pr:1, pc:1, e_ph:1, e_ss:1,
                         e_rows:1, e_cols:1, e_bd:1, e_disp:8'h3C, default:0});
        vecs.push_back('{us:1, e_ph:3, e_err:2, e_fl:1, e_rows:1, e_cols:1, e_bd:1, e_disp:8'h3C, default:0});
        vecs.push_back('{clr:1, e_fl:1, e_rows:1, e_cols:1, e_bd:1, e_disp:8'h3C, default:0});
        vecs.push_back('{pd:1, pr:11, pc:12, e_ph:3, e_err:4, e_fl:1,
                         e_rows:1, e_cols:1, e_bd:1, e_disp:8'h3C, default:0});
        vecs.push_back('{clr:1, e_fl:1, e_rows:1, e_cols:1, e_bd:1, e_disp:8'h3C, default:0});
        vecs.push_back('{pw:1, full:1, pd:1, pr:2, pc:2, e_ph:3, e_err:1, e_fl:1,
                         e_rows:1, e_cols:1, e_bd:1, e_disp:8'h3C, default:0});
        vecs.push_back('{clr:1, e_fl:1, e_rows:1, e_cols:1, e_bd:1, e_disp:8'h3C, default:0});
        vecs.push_back('{pd:1, pr:2, pc:3, e_ph:1, e_ss:1,
                         e_rows:2, e_cols:3, e_bd:1, e_disp:8'h3C, default:0});
        vecs.push_back('{sw:1, sl:16'h5555, full:1, sv:1, e_din:16'h5555, e_ph:3, e_err:1, e_fl:1,
                         e_rows:2, e_cols:3, e_bd:1, e_disp:8'h3C, default:0});
        vecs.push_back('{clr:1, rxv:1, rxb:8'h5A, e_fl:1,
                         e_rows:2, e_cols:3, e_bd:1, e_disp:8'h5A, default:0});
        vecs.push_back('{full:1, e_rows:2, e_cols:3, e_bd:1, e_disp:8'h5A, default:0});

        // Reset state
        tick();
        chk("rst_phase", 32'(phase), 32'(0));
        chk("rst_err", 32'(err_code), 32'(0));
        chk("rst_rows", 32'(rows_q), 32'(0));
        chk("rst_boards", 32'(boards_done), 32'(0));
        chk("rst_disp", 32'(disp), 32'(0));
        chk("rst_flush", 32'(fif.fifo_flush), 32'(0));
        chk("rst_ss", 32'(solve_start), 32'(0));
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            apply(vecs[i]);
            #1;
            chk($sformatf("v%0d_wr_en", i), 32'(fif.fifo_wr_en), 32'(vecs[i].e_wr));
            chk($sformatf("v%0d_din", i), 32'(fif.fifo_din), 32'(vecs[i].e_din));
            tick();
            chk($sformatf("v%0d_phase", i), 32'(phase), 32'(vecs[i].e_ph));
            chk($sformatf("v%0d_err", i), 32'(err_code), 32'(vecs[i].e_err));
            chk($sformatf("v%0d_solve_start", i), 32'(solve_start), 32'(vecs[i].e_ss));
            chk($sformatf("v%0d_asm_start", i), 32'(asm_start), 32'(vecs[i].e_as));
            chk($sformatf("v%0d_flush", i), 32'(fif.fifo_flush), 32'(vecs[i].e_fl));
            chk($sformatf("v%0d_rows", i), 32'(rows_q), 32'(vecs[i].e_rows));
            chk($sformatf("v%0d_cols", i), 32'(cols_q), 32'(vecs[i].e_cols));
            chk($sformatf("v%0d_boards", i), 32'(boards_done), 32'(vecs[i].e_bd));
            chk($sformatf("v%0d_disp", i), 32'(disp), 32'(vecs[i].e_disp));
        end
        clr_in();
        exp_bd = 1;

        // Watchdog expiry: 16 SOLVE cycles without solved
        parse_done = 1; parse_rows = 11; parse_cols = 11;
        tick(); clr_in();
        chk("wd_enter_phase", 32'(phase), 32'(1));
        for (int k = 2; k <= 16; k++) begin
            tick();
            chk($sformatf("wd_hold%0d", k), 32'(phase), 32'(1));
        end
        tick();
        chk("wd_expire_phase", 32'(phase), 32'(3));
        chk("wd_expire_err", 32'(err_code), 32'(3));
        chk("wd_expire_flush", 32'(fif.fifo_flush), 32'(1));
        clear_err = 1;
        tick(); clr_in();
        chk("wd_clear_phase", 32'(phase), 32'(0));

        // solved in the 16th SOLVE cycle still wins over expiry
        parse_done = 1; parse_rows = 4; parse_cols = 7;
        tick(); clr_in();
        repeat (15) tick();
        chk("wd16_still_solve", 32'(phase), 32'(1));
        solved = 1;
        tick(); clr_in();
        chk("wd16_phase", 32'(phase), 32'(2));
        chk("wd16_asm_start", 32'(asm_start), 32'(1));
        assembled = 1;
        tick(); clr_in();
        exp_bd++;
        chk("wd16_boards", 32'(boards_done), 32'(exp_bd));

        // boards_done saturation
        for (int b = 0; b < 256; b++) begin
            board(4'd5, 4'd5);
            if (exp_bd < 255) exp_bd++;
            chk($sformatf("sat_b%0d", b), 32'(boards_done), 32'(exp_bd));
        end
        chk("sat_final", 32'(boards_done), 32'(255));

        // Asynchronous reset in the first SOLVE cycle
        rx_valid = 1; rx_byte = 8'hC3;
        tick(); clr_in();
        parse_done = 1; parse_rows = 6; parse_cols = 9;
        tick(); clr_in();
        chk("prerst_phase", 32'(phase), 32'(1));
        chk("prerst_ss", 32'(solve_start), 32'(1));
        rst_n = 1'b0;
        #1;
        chk("arst_phase", 32'(phase), 32'(0));
        chk("arst_ss", 32'(solve_start), 32'(0));
        chk("arst_rows", 32'(rows_q), 32'(0));
        chk("arst_cols", 32'(cols_q), 32'(0));
        chk("arst_boards", 32'(boards_done), 32'(0));
        chk("arst_disp", 32'(disp), 32'(0));
        chk("arst_err", 32'(err_code), 32'(0));
        chk("arst_flush", 32'(fif.fifo_flush), 32'(0));
        chk("arst_wr_en", 32'(fif.fifo_wr_en), 32'(0));
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_flush", 32'(fif.fifo_flush), 32'(0));
        chk("post_rst_phase", 32'(phase), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
